psram_req_arbiter: RTL and testbench

Shares the single QSPI PSRAM controller between three requesters: instruction fetch (IF), data memory (DM) and the UART debug/loader (DBG).
- Accepts one word transaction at a time, issues it to the controller, waits for completion and returns an ack plus read data to the winner.
- Sits in fpga_top between the CPU/debug masters and the qspi controller. The debug loader can preload memory before cpu_start.

---
 rtl/psram_req_arbiter_pkg.sv | 24 ++
 rtl/psram_rr_pick.sv | 28 ++
 rtl/psram_req_arbiter.sv | 150 +++++++++++++++
 tb/tb_psram_req_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_req_arbiter_pkg.sv
// Shared types and constants for the PSRAM request arbiter and its winner-select helper.
package psram_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [1:0] req_idx_t;

  localparam int unsigned N_REQ = 3;
  localparam req_idx_t REQ_IF  = 2'd0;
  localparam req_idx_t REQ_DM  = 2'd1;
  localparam req_idx_t REQ_DBG = 2'd2;

  localparam int unsigned TMO_W = 10;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input req_idx_t idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/psram_rr_pick.sv
// Combinational winner select: DBG has fixed top priority, IF/DM alternate on a tie.
module psram_rr_pick
  import psram_req_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  req_idx_t         rr_last_i,
  output logic             valid_o,
  output logic [N_REQ-1:0] grant_o,
  output req_idx_t         idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = REQ_IF;
    if (req_i[REQ_DBG]) begin
      idx_o = REQ_DBG;
    end else if (req_i[REQ_IF] && req_i[REQ_DM]) begin
      idx_o = (rr_last_i == REQ_IF) ? REQ_DM : REQ_IF;
    end else if (req_i[REQ_DM]) begin
      idx_o = REQ_DM;
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
    assign grant_o[gi] = valid_o && (idx_o == req_idx_t'(gi));
  end

endmodule

// File: rtl/psram_req_arbiter.sv
// Shares one PSRAM controller among IF, DM and DBG; one word transaction in flight at a time,
// with a bounded wait on the controller and a one-hot ack back to the winner.
module psram_req_arbiter
  import psram_req_arbiter_pkg::*;
#(
  parameter int unsigned ADR_W   = 22,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TMO_CYC = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              req,
  input  logic [2:0]              we,
  input  logic [3*ADR_W-1:0]      adr,
  input  logic [3*DATA_W-1:0]     wdata,
  output logic [2:0]              ack,
  output logic                    err,
  output logic [DATA_W-1:0]       rdata,
  output logic                    mem_start,
  output logic                    mem_we,
  output logic [ADR_W-1:0]        mem_adr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_busy,
  input  logic                    mem_done,
  input  logic [DATA_W-1:0]       mem_rdata
);

  logic [ADR_W-1:0]  adr_slot   [N_REQ];
  logic [DATA_W-1:0] wdata_slot [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign adr_slot[gi]   = adr[gi*ADR_W +: ADR_W];
    assign wdata_slot[gi] = wdata[gi*DATA_W +: DATA_W];
  end

  state_e            state_q, state_d;
  req_idx_t          sel_q, sel_d;
  req_idx_t          rr_last_q, rr_last_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_start_q, mem_start_d;
  logic              mem_we_q, mem_we_d;
  logic [ADR_W-1:0]  mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              pick_valid;
  logic [N_REQ-1:0]  pick_grant;
  req_idx_t          pick_idx;

  psram_rr_pick u_pick (
    .req_i     (req),
    .rr_last_i (rr_last_q),
    .valid_o   (pick_valid),
    .grant_o   (pick_grant),
    .idx_o     (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_last_d   = rr_last_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    mem_start_d = 1'b0;
    mem_we_d    = mem_we_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          sel_d       = pick_idx;
          mem_we_d    = |(we & pick_grant);
          mem_adr_d   = adr_slot[pick_idx];
          mem_wdata_d = wdata_slot[pick_idx];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (!mem_busy) begin
          mem_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A completion arriving on the timeout cycle still counts as success.
        if (mem_done) begin
          ack_d   = idx_to_onehot(sel_q);
          rdata_d = mem_we_q ? '0 : mem_rdata;
          state_d = DONE;
        end else if (cnt_q == TMO_W'(TMO_CYC)) begin
          ack_d   = idx_to_onehot(sel_q);
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (sel_q != REQ_DBG) begin
          rr_last_d = sel_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= REQ_IF;
      rr_last_q   <= REQ_DM;
      cnt_q       <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_start_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_last_q   <= rr_last_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_start_q <= mem_start_d;
      mem_we_q    <= mem_we_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_start = mem_start_q;
  assign mem_we    = mem_we_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_psram_req_arbiter.sv
// Bench for psram_req_arbiter: behavioural PSRAM controller plus a transaction-level model
// predicting winner order, read data, error flag and issue/ack timing.
module tb_psram_req_arbiter;

  localparam int ADR_W   = 22;
  localparam int DATA_W  = 32;
  localparam int TMO_CYC = 1023;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADR_W-1:0]  adr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          ack;
  logic                err;
  logic [DATA_W-1:0]   rdata;
  logic                mem_start;
  logic                mem_we;
  logic [ADR_W-1:0]    mem_adr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_busy;
  logic                mem_done;
  logic [DATA_W-1:0]   mem_rdata;

  psram_req_arbiter #(.ADR_W(ADR_W), .DATA_W(DATA_W), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .adr(adr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .mem_start(mem_start), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_busy(mem_busy),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic              we;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  txn_t        tq [3][$];
  logic [31:0] ref_mem [int];
  logic [31:0] ctl_mem [int];
  int          rr_last_m = 1;
  int          start_q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_txn = 0;

  int                ctl_lat = 4;
  bit                ctl_suppress = 1'b0;
  logic              c_we;
  logic [ADR_W-1:0]  c_adr;
  logic [DATA_W-1:0] c_wdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    return 32'h5A00_0000 ^ (a * 32'h0000_9E37);
  endfunction

  // Behavioural controller: answers each mem_start after ctl_lat cycles, aborts on reset.
  initial begin
    bit aborted;
    mem_done  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (mem_start && rst_n) begin
        c_we    = mem_we;
        c_adr   = mem_adr;
        c_wdata = mem_wdata;
        start_q.push_back(cyc);
        aborted = 1'b0;
        for (int k = 0; k < ctl_lat; k++) begin
          @(posedge clk); #2;
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted && !ctl_suppress) begin
          if (c_we) begin
            ctl_mem[int'(c_adr)] = c_wdata;
            mem_rdata = $urandom();
          end else begin
            mem_rdata = ctl_mem.exists(int'(c_adr)) ? ctl_mem[int'(c_adr)] : init_word(int'(c_adr));
          end
          mem_done = 1'b1;
          @(posedge clk); #2;
          mem_done = 1'b0;
        end
      end
    end
  end

  function automatic int model_pick();
    if (tq[2].size() > 0) return 2;
    if (tq[0].size() > 0 && tq[1].size() > 0) return (rr_last_m == 0) ? 1 : 0;
    if (tq[1].size() > 0) return 1;
    return 0;
  endfunction

  task automatic drive_req(input int i);
    req[i] = 1'b1;
    we[i]  = tq[i][0].we;
    adr[i*ADR_W +: ADR_W]    = tq[i][0].adr;
    wdata[i*DATA_W +: DATA_W] = tq[i][0].wdata;
  endtask

  task automatic push_txn(input int i, input logic w, input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d);
    txn_t t;
    t.we = w; t.adr = a; t.wdata = d;
    tq[i].push_back(t);
  endtask

  task automatic check_onehot();
    logic [2:0] dup;
    dup = ack & (ack - 3'd1);
    chk("ack_onehot", dup, 3'd0);
  endtask

  // Issues everything queued in tq; requesters re-raise the cycle after their ack.
  task automatic run_batch(input int lat, input bit suppress, input int busy_cyc);
    int remaining, c0, exp_start, exp_lat, guard, w, s;
    bit raise_next [3];
    txn_t t;
    logic [31:0] exp_rd;
    ctl_lat = lat;
    ctl_suppress = suppress;
    exp_lat = suppress ? TMO_CYC + 1 : lat + 1;
    remaining = tq[0].size() + tq[1].size() + tq[2].size();
    for (int i = 0; i < 3; i++) raise_next[i] = 1'b0;
    @(posedge clk); #1;
    c0 = cyc;
    for (int i = 0; i < 3; i++) if (tq[i].size() > 0) drive_req(i);
    if (busy_cyc > 0) mem_busy = 1'b1;
    exp_start = c0 + 2 + busy_cyc;
    guard = 0;
    while (remaining > 0) begin
      @(posedge clk); #1;
      guard++;
      if (busy_cyc > 0 && cyc == c0 + busy_cyc + 1) mem_busy = 1'b0;
      for (int i = 0; i < 3; i++) if (raise_next[i]) begin drive_req(i); raise_next[i] = 1'b0; end
      check_onehot();
      if (ack != 3'd0) begin
        w = model_pick();
        t = tq[w][0];
        exp_rd = (suppress || t.we) ? 32'h0 :
                 (ref_mem.exists(int'(t.adr)) ? ref_mem[int'(t.adr)] : init_word(int'(t.adr)));
        chk("ack_sel", ack, 3'b001 << w);
        chk("err", err, suppress);
        chk("rdata", rdata, exp_rd);
        chk("issue_count", start_q.size(), 1);
        s = (start_q.size() > 0) ? start_q.pop_front() : -1;
        chk("start_cycle", s, exp_start);
        chk("ack_latency", cyc - s, exp_lat);
        chk("mem_we", c_we, t.we);
        chk("mem_adr", c_adr, t.adr);
        if (t.we) chk("mem_wdata", c_wdata, t.wdata);
        $display("txn %0d: req%0d we=%0b adr=%h wdata=%h -> ack=%b err=%0b rdata=%h start@%0d ack@%0d",
                 n_txn, w, t.we, t.adr, t.wdata, ack, err, rdata, s, cyc);
        n_txn++;
        if (w != 2) rr_last_m = w;
        if (t.we && !suppress) ref_mem[int'(t.adr)] = t.wdata;
        void'(tq[w].pop_front());
        remaining--;
        req[w] = 1'b0;
        if (tq[w].size() > 0) raise_next[w] = 1'b1;
        exp_start = cyc + 3;
        guard = 0;
      end else if (guard > TMO_CYC + 100) begin
        chk("ack_wait", ack, 3'b001 << model_pick());
        for (int i = 0; i < 3; i++) tq[i].delete();
        req = '0;
        remaining = 0;
      end
    end
    mem_busy = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req = '0; we = '0; adr = '0; wdata = '0; mem_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 3'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_start", mem_start, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_adr", mem_adr, 22'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    ctl_mem[32'h100] = 32'h0000_0013;
    ref_mem[32'h100] = 32'h0000_0013;

    // IF alone
    push_txn(0, 1'b0, 22'h000100, 32'h0);
    run_batch(8, 1'b0, 0);

    // DBG write and IF read raised together
    push_txn(2, 1'b1, 22'h000000, 32'hDEADBEEF);
    push_txn(0, 1'b0, 22'h000000, 32'h0);
    run_batch(3, 1'b0, 0);

    // IF and DM contending for four transactions
    for (int i = 0; i < 2; i++) begin
      push_txn(0, 1'b0, 22'h000100, 32'h0);
      push_txn(1, 1'b1, 22'h000040 + 22'(i), 32'hC0DE_0000 + 32'(i));
    end
    run_batch(2, 1'b0, 0);

    // stray mem_done while idle
    @(posedge clk); #1; mem_done = 1'b1;
    @(posedge clk); #1; mem_done = 1'b0;
    chk("stray_done_ack", ack, 3'd0);
    @(posedge clk); #1;
    chk("stray_done_ack2", ack, 3'd0);

    // timeout, then a normal request
    push_txn(0, 1'b0, 22'h000100, 32'h0);
    run_batch(8, 1'b1, 0);
    push_txn(1, 1'b0, 22'h000040, 32'h0);
    run_batch(5, 1'b0, 0);

    // completion on the very cycle the timeout would fire
    push_txn(0, 1'b0, 22'h000041, 32'h0);
    run_batch(TMO_CYC, 1'b0, 0);

    // controller busy for 5 cycles after the grant
    push_txn(1, 1'b1, 22'h000123, 32'h1234_5678);
    push_txn(0, 1'b0, 22'h000123, 32'h0);
    run_batch(3, 1'b0, 5);

    // reset during WAIT
    ctl_lat = 20; ctl_suppress = 1'b0;
    @(posedge clk); #1;
    req = 3'b001; we = 3'b000; adr[0 +: ADR_W] = 22'h3ABCD;
    for (int k = 0; k < 10 && start_q.size() == 0; k++) begin
      @(posedge clk); #1;
    end
    chk("rst_test_started", start_q.size(), 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0; req = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_ack", ack, 3'd0);
    chk("abort_err", err, 1'b0);
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_mem_start", mem_start, 1'b0);
    chk("abort_mem_we", mem_we, 1'b0);
    chk("abort_mem_adr", mem_adr, 22'h0);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      chk("abort_no_ack", ack, 3'd0);
    end
    start_q.delete();
    rr_last_m = 1;
    push_txn(1, 1'b0, 22'h000100, 32'h0);
    run_batch(4, 1'b0, 0);

    // randomized batches over a small address window so reads hit earlier writes
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 3; i++) begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++)
          push_txn(i, 1'($urandom_range(0, 1)), 22'h000200 + 22'($urandom_range(0, 7)), $urandom());
      end
      if (tq[0].size() + tq[1].size() + tq[2].size() == 0)
        push_txn(1, 1'b0, 22'h000200, 32'h0);
      run_batch($urandom_range(1, 6), 1'b0, $urandom_range(0, 1) * $urandom_range(1, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
